// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs
// Desc     : ALU reservation station. Buffers dispatched instructions until
//            both source operands are resolved from the two result buses,
//            then issues one ready entry per cycle to the ALU.
//            Optional macro ALU_RS_AGE_EN: each entry carries a saturating
//            age counter and the oldest ready entry issues first (ties go to
//            the lowest index). Without it the lowest-index ready entry wins.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rs #(
  parameter int RS_SIZE    = 8,
  parameter int ROB_SZ_LOG = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                clr,
  input  logic                in_flg,
  input  logic [3:0]          in_opcode,
  input  logic [3:0]          in_optype,
  input  logic [31:0]         in_Vj,
  input  logic [31:0]         in_Vk,
  input  logic [31:0]         in_imm,
  input  logic [31:0]         in_pc,
  input  logic [ROB_SZ_LOG:0] in_Qj,
  input  logic [ROB_SZ_LOG:0] in_Qk,
  input  logic [ROB_SZ_LOG:0] in_rd,
  input  logic                cdb0_flg,
  input  logic [ROB_SZ_LOG:0] cdb0_rd,
  input  logic [31:0]         cdb0_res,
  input  logic                cdb1_flg,
  input  logic [ROB_SZ_LOG:0] cdb1_rd,
  input  logic [31:0]         cdb1_res,
  output logic                full,
  output logic                run_flg,
  output logic [ROB_SZ_LOG:0] rd_fr,
  output logic [31:0]         Vj,
  output logic [31:0]         Vk,
  output logic [31:0]         imm,
  output logic [31:0]         pc,
  output logic [3:0]          opcode,
  output logic [3:0]          optype
);

  localparam int c_IDX_W = $clog2(RS_SIZE);
  localparam int c_CNT_W = c_IDX_W + 1;
  localparam int c_TAG_W = ROB_SZ_LOG + 1;

  // Entry storage
  logic               r_busy   [RS_SIZE];
  logic [3:0]         r_opcode [RS_SIZE];
  logic [3:0]         r_optype [RS_SIZE];
  logic [31:0]        r_vj     [RS_SIZE];
  logic [31:0]        r_vk     [RS_SIZE];
  logic [c_TAG_W-1:0] r_qj     [RS_SIZE];
  logic [c_TAG_W-1:0] r_qk     [RS_SIZE];
  logic [31:0]        r_imm    [RS_SIZE];
  logic [31:0]        r_pc     [RS_SIZE];
  logic [c_TAG_W-1:0] r_rd     [RS_SIZE];
`ifdef ALU_RS_AGE_EN
  logic [3:0]         r_age    [RS_SIZE];
  logic [3:0]         w_best_age;
`endif
  logic [c_CNT_W-1:0] r_count;

  logic               w_ready  [RS_SIZE];
  logic               w_issue_vld;
  logic [c_IDX_W-1:0] w_issue_idx;
  logic               w_free_vld;
  logic [c_IDX_W-1:0] w_free_idx;
  logic               w_disp;
  logic [c_CNT_W-1:0] w_count_nxt;

  // Resolve a source tag against the result buses; bus 0 has priority.
  // Returns {tag, value}; a hit clears the tag and substitutes the result.
  function automatic logic [c_TAG_W+31:0] f_capture(input logic [c_TAG_W-1:0] q,
                                                    input logic [31:0]        v);
    if (q != '0 && cdb0_flg && cdb0_rd == q) return {{c_TAG_W{1'b0}}, cdb0_res};
    if (q != '0 && cdb1_flg && cdb1_rd == q) return {{c_TAG_W{1'b0}}, cdb1_res};
    return {q, v};
  endfunction

  // Readiness reflects entry state at the start of the cycle only
  generate
    for (genvar g = 0; g < RS_SIZE; g++) begin : g_ready
      assign w_ready[g] = r_busy[g] && (r_qj[g] == '0) && (r_qk[g] == '0);
    end
  endgenerate

  // Issue select: lowest-index ready entry, or oldest ready when ages exist
  always_comb begin
    w_issue_vld = 1'b0;
    w_issue_idx = '0;
`ifdef ALU_RS_AGE_EN
    w_best_age  = '0;
`endif
    for (int i = 0; i < RS_SIZE; i++) begin
      if (w_ready[i]) begin
`ifdef ALU_RS_AGE_EN
        if (!w_issue_vld || r_age[i] > w_best_age) begin
          w_issue_vld = 1'b1;
          w_issue_idx = c_IDX_W'(i);
          w_best_age  = r_age[i];
        end
`else
        if (!w_issue_vld) begin
          w_issue_vld = 1'b1;
          w_issue_idx = c_IDX_W'(i);
        end
`endif
      end
    end
  end

  // Dispatch target: lowest-index slot that is free before this edge, so a
  // slot vacated by issue this cycle is never reused on the same edge
  always_comb begin
    w_free_vld = 1'b0;
    w_free_idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!r_busy[i] && !w_free_vld) begin
        w_free_vld = 1'b1;
        w_free_idx = c_IDX_W'(i);
      end
    end
  end

  assign w_disp      = in_flg && w_free_vld && (r_count != c_CNT_W'(RS_SIZE));
  assign w_count_nxt = r_count + c_CNT_W'(w_disp) - c_CNT_W'(w_issue_vld);

  // Entry state, occupancy, and registered issue outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RS_SIZE; i++) r_busy[i] <= 1'b0;
      r_count <= '0;
      full    <= 1'b0;
      run_flg <= 1'b0;
      rd_fr   <= '0;
      Vj      <= '0;
      Vk      <= '0;
      imm     <= '0;
      pc      <= '0;
      opcode  <= '0;
      optype  <= '0;
    end else if (!rdy) begin
      run_flg <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < RS_SIZE; i++) r_busy[i] <= 1'b0;
      r_count <= '0;
      full    <= 1'b0;
      run_flg <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i]) begin
          {r_qj[i], r_vj[i]} <= f_capture(r_qj[i], r_vj[i]);
          {r_qk[i], r_vk[i]} <= f_capture(r_qk[i], r_vk[i]);
`ifdef ALU_RS_AGE_EN
          if (r_age[i] != 4'hF) r_age[i] <= r_age[i] + 4'd1;
`endif
        end
      end
      if (w_issue_vld) begin
        r_busy[w_issue_idx] <= 1'b0;
        run_flg <= 1'b1;
        rd_fr   <= r_rd[w_issue_idx];
        Vj      <= r_vj[w_issue_idx];
        Vk      <= r_vk[w_issue_idx];
        imm     <= r_imm[w_issue_idx];
        pc      <= r_pc[w_issue_idx];
        opcode  <= r_opcode[w_issue_idx];
        optype  <= r_optype[w_issue_idx];
      end else begin
        run_flg <= 1'b0;
      end
      if (w_disp) begin
        r_busy[w_free_idx]   <= 1'b1;
        r_opcode[w_free_idx] <= in_opcode;
        r_optype[w_free_idx] <= in_optype;
        r_imm[w_free_idx]    <= in_imm;
        r_pc[w_free_idx]     <= in_pc;
        r_rd[w_free_idx]     <= in_rd;
        {r_qj[w_free_idx], r_vj[w_free_idx]} <= f_capture(in_Qj, in_Vj);
        {r_qk[w_free_idx], r_vk[w_free_idx]} <= f_capture(in_Qk, in_Vk);
`ifdef ALU_RS_AGE_EN
        r_age[w_free_idx]    <= 4'd0;
`endif
      end
      r_count <= w_count_nxt;
      full    <= (w_count_nxt >= c_CNT_W'(RS_SIZE - 1));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_rs.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rs
// Desc     : Self-checking bench for alu_rs: directed scenarios followed by
//            randomized traffic compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rs;

  localparam int RS = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst, rdy, clr, in_flg;
  logic [3:0]    in_opcode, in_optype;
  logic [31:0]   in_Vj, in_Vk, in_imm, in_pc;
  logic [TW-1:0] in_Qj, in_Qk, in_rd;
  logic          cdb0_flg, cdb1_flg;
  logic [TW-1:0] cdb0_rd, cdb1_rd;
  logic [31:0]   cdb0_res, cdb1_res;
  logic          full, run_flg;
  logic [TW-1:0] rd_fr;
  logic [31:0]   Vj, Vk, imm, pc;
  logic [3:0]    opcode, optype;

  always #5 clk = ~clk;

  alu_rs #(.RS_SIZE(RS), .ROB_SZ_LOG(3)) u_dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .in_flg(in_flg),
    .in_opcode(in_opcode), .in_optype(in_optype),
    .in_Vj(in_Vj), .in_Vk(in_Vk), .in_imm(in_imm), .in_pc(in_pc),
    .in_Qj(in_Qj), .in_Qk(in_Qk), .in_rd(in_rd),
    .cdb0_flg(cdb0_flg), .cdb0_rd(cdb0_rd), .cdb0_res(cdb0_res),
    .cdb1_flg(cdb1_flg), .cdb1_rd(cdb1_rd), .cdb1_res(cdb1_res),
    .full(full), .run_flg(run_flg), .rd_fr(rd_fr),
    .Vj(Vj), .Vk(Vk), .imm(imm), .pc(pc), .opcode(opcode), .optype(optype)
  );

  // Behavioural model: a table of slots, each with its unresolved tags and
  // the number of cycles it has been waiting
  typedef struct {
    bit            busy;
    logic [3:0]    opc, opt;
    logic [31:0]   vj, vk, imm, pc;
    logic [TW-1:0] qj, qk, rd;
    int            age;
  } ent_t;

  ent_t          m [RS];
  int            m_count = 0;
  logic          e_run, e_full;
  logic [TW-1:0] e_rd;
  logic [31:0]   e_vj, e_vk, e_imm, e_pc;
  logic [3:0]    e_opc, e_opt;
  int            n_checks = 0;
  int            n_errors = 0;
  int            pulses;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat15(input int a);
    return (a > 15) ? 15 : a;
  endfunction

  // Value of a source after looking at the buses this cycle (bus 0 first)
  task automatic resolve(inout logic [TW-1:0] q, inout logic [31:0] v);
    if (q != 0) begin
      if (cdb0_flg && cdb0_rd == q) begin v = cdb0_res; q = 0; end
      else if (cdb1_flg && cdb1_rd == q) begin v = cdb1_res; q = 0; end
    end
  endtask

  task automatic model_step();
    int sel, fr, cnt0;
    logic [TW-1:0] q;
    logic [31:0] v;
    if (!rst) begin
      foreach (m[i]) m[i].busy = 0;
      m_count = 0;
      e_run = 0; e_full = 0; e_rd = 0; e_vj = 0; e_vk = 0;
      e_imm = 0; e_pc = 0; e_opc = 0; e_opt = 0;
      return;
    end
    if (!rdy) begin e_run = 0; return; end
    if (clr) begin
      foreach (m[i]) m[i].busy = 0;
      m_count = 0; e_full = 0; e_run = 0;
      return;
    end
    cnt0 = m_count;
    sel = -1;
    fr  = -1;
    for (int i = 0; i < RS; i++) begin
      if (m[i].busy && m[i].qj == 0 && m[i].qk == 0) begin
`ifdef ALU_RS_AGE_EN
        if (sel < 0 || sat15(m[i].age) > sat15(m[sel].age)) sel = i;
`else
        if (sel < 0) sel = i;
`endif
      end
      if (!m[i].busy && fr < 0) fr = i;
    end
    if (sel >= 0) begin
      e_run = 1; e_rd = m[sel].rd; e_vj = m[sel].vj; e_vk = m[sel].vk;
      e_imm = m[sel].imm; e_pc = m[sel].pc; e_opc = m[sel].opc; e_opt = m[sel].opt;
      m[sel].busy = 0;
      m_count--;
    end else begin
      e_run = 0;
    end
    for (int i = 0; i < RS; i++) begin
      if (m[i].busy) begin
        q = m[i].qj; v = m[i].vj; resolve(q, v); m[i].qj = q; m[i].vj = v;
        q = m[i].qk; v = m[i].vk; resolve(q, v); m[i].qk = q; m[i].vk = v;
        m[i].age++;
      end
    end
    if (in_flg && cnt0 < RS && fr >= 0) begin
      m[fr].busy = 1; m[fr].opc = in_opcode; m[fr].opt = in_optype;
      m[fr].imm = in_imm; m[fr].pc = in_pc; m[fr].rd = in_rd; m[fr].age = 0;
      q = in_Qj; v = in_Vj; resolve(q, v); m[fr].qj = q; m[fr].vj = v;
      q = in_Qk; v = in_Vk; resolve(q, v); m[fr].qk = q; m[fr].vk = v;
      m_count++;
    end
    e_full = (m_count >= RS - 1);
  endtask

  // One clock: advance the model with the current inputs, then compare
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_eq("run_flg", run_flg, e_run);
    check_eq("full", full, e_full);
    check_eq("rd_fr", rd_fr, e_rd);
    check_eq("Vj", Vj, e_vj);
    check_eq("Vk", Vk, e_vk);
    check_eq("imm", imm, e_imm);
    check_eq("pc", pc, e_pc);
    check_eq("opcode", opcode, e_opc);
    check_eq("optype", optype, e_opt);
  endtask

  task automatic idle();
    rst = 1; rdy = 1; clr = 0; in_flg = 0; cdb0_flg = 0; cdb1_flg = 0;
  endtask

  task automatic disp(input logic [3:0] opc, input logic [31:0] vj, input logic [TW-1:0] qj,
                      input logic [31:0] vk, input logic [TW-1:0] qk,
                      input logic [31:0] im, input logic [TW-1:0] rd);
    in_flg = 1; in_opcode = opc; in_optype = 4'h1; in_Vj = vj; in_Qj = qj;
    in_Vk = vk; in_Qk = qk; in_imm = im; in_pc = 32'h1000 + 32'(rd); in_rd = rd;
  endtask

  initial begin
    idle();
    rst = 0;
    in_opcode = 0; in_optype = 0; in_Vj = 0; in_Vk = 0; in_imm = 0; in_pc = 0;
    in_Qj = 0; in_Qk = 0; in_rd = 0; cdb0_rd = 0; cdb1_rd = 0; cdb0_res = 0; cdb1_res = 0;
    tick(); tick();
    check_eq("rst_run", run_flg, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_rd", rd_fr, 0);

    // Ready ADDI issues right after the following edge, for one cycle
    idle(); disp(4'h1, 5, 0, 0, 0, 3, 2); tick();
    check_eq("addi_early", run_flg, 0);
    idle(); tick();
    check_eq("addi_run", run_flg, 1);
    check_eq("addi_rd", rd_fr, 2);
    check_eq("addi_vj", Vj, 5);
    check_eq("addi_imm", imm, 3);
    tick();
    check_eq("addi_once", run_flg, 0);

    // Wakeup from the load/store bus
    idle(); disp(4'h0, 0, 4, 9, 0, 0, 6); tick();
    idle(); tick();
    cdb1_flg = 1; cdb1_rd = 4; cdb1_res = 32'h10; tick();
    check_eq("wake_wait", run_flg, 0);
    idle(); tick();
    check_eq("wake_run", run_flg, 1);
    check_eq("wake_vj", Vj, 32'h10);
    check_eq("wake_rd", rd_fr, 6);

    // Operand captured from the bus on the dispatch edge
    idle(); disp(4'h2, 1, 0, 32'hdead, 3, 0, 5);
    cdb0_flg = 1; cdb0_rd = 3; cdb0_res = 7; tick();
    idle(); tick();
    check_eq("cap_run", run_flg, 1);
    check_eq("cap_vk", Vk, 7);

    // Fill to seven waiting entries, release one, then keep dispatching
    idle(); clr = 1; tick();
    for (int k = 0; k < 7; k++) begin
      idle(); disp(4'h3, 0, (k == 6) ? 4'd10 : 4'd9, 1, 0, 0, 4'(k + 1)); tick();
      if (k == 5) check_eq("fill6_full", full, 0);
    end
    check_eq("fill7_full", full, 1);
    idle(); cdb0_flg = 1; cdb0_rd = 10; cdb0_res = 1; tick();
    check_eq("fill_wake_full", full, 1);
    idle(); tick();
    check_eq("fill_iss_run", run_flg, 1);
    check_eq("fill_iss_rd", rd_fr, 7);
    check_eq("fill_iss_full", full, 0);
    idle(); disp(4'h3, 0, 9, 1, 0, 0, 8); tick();
    idle(); disp(4'h3, 0, 9, 1, 0, 0, 9); tick();
    check_eq("fill8_full", full, 1);
    idle(); cdb1_flg = 1; cdb1_rd = 9; cdb1_res = 32'h99; tick();
    idle(); pulses = 0;
    for (int k = 0; k < 12; k++) begin tick(); if (run_flg) pulses++; end
    check_eq("fill_drain", pulses, 8);

    // Slot 1 older than slot 0, both become ready together
    idle(); clr = 1; tick();
    idle(); disp(4'h4, 1, 0, 1, 0, 0, 11); tick();
    idle(); disp(4'h4, 2, 6, 1, 0, 0, 12); tick();
    idle(); disp(4'h4, 3, 6, 1, 0, 0, 13); tick();
    idle(); cdb0_flg = 1; cdb0_rd = 6; cdb0_res = 32'h55; tick();
    idle(); tick();
`ifdef ALU_RS_AGE_EN
    check_eq("age_first", rd_fr, 12);
`else
    check_eq("age_first", rd_fr, 13);
`endif
    tick();
`ifdef ALU_RS_AGE_EN
    check_eq("age_second", rd_fr, 13);
`else
    check_eq("age_second", rd_fr, 12);
`endif

    // Flush overrides a concurrent dispatch and discards waiting entries
    idle(); tick();
    for (int k = 0; k < 3; k++) begin idle(); disp(4'h5, 0, 11, 0, 0, 0, 4'(k + 1)); tick(); end
    idle(); disp(4'h5, 1, 0, 1, 0, 0, 14); clr = 1; tick();
    check_eq("flush_run", run_flg, 0);
    check_eq("flush_full", full, 0);
    idle(); cdb0_flg = 1; cdb0_rd = 11; cdb0_res = 4; tick();
    idle(); pulses = 0;
    for (int k = 0; k < 5; k++) begin tick(); if (run_flg) pulses++; end
    check_eq("flush_none", pulses, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst = ($urandom_range(199) != 0);
      rdy = ($urandom_range(9) != 0);
      clr = ($urandom_range(39) == 0);
      if ($urandom_range(9) < 6)
        disp(4'($urandom), $urandom, ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(1, 7)),
             $urandom, ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(1, 7)),
             $urandom, 4'($urandom_range(1, 15)));
      in_optype = 4'($urandom_range(3));
      cdb0_flg = ($urandom_range(9) < 4); cdb0_rd = 4'($urandom_range(1, 7)); cdb0_res = $urandom;
      cdb1_flg = ($urandom_range(9) < 4); cdb1_rd = 4'($urandom_range(1, 7)); cdb1_res = $urandom;
      if (cdb1_rd == cdb0_rd) cdb1_rd = cdb0_rd ^ 4'd1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter: RS_SIZE, default 8, number of reservation-station entries; power of two, 2..16.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous and active-low: clears state at a clk rising edge while rst is low.
REQ-004 rdy  in  1  global enable; low freezes all state.
REQ-005 clr  in  1  flush on branch mispredict.
REQ-006 in_flg  in  1  dispatch valid.
REQ-007 in_opcode, in_optype  in  4 each  operation code and class (CAL, CALi, BRA, JUM).
REQ-008 in_Vj, in_Vk, in_imm, in_pc  in  32 each  operand values, immediate, instruction pc.
REQ-009 in_Qj, in_Qk, in_rd  in  ROB_SZ_LOG+1 each  source tags and destination ROB tag; tag 0 means "no dependency".
REQ-010 cdb0_flg, cdb1_flg  in  1 each  result-bus valids (ALU bus, load/store bus).
REQ-011 cdb0_rd, cdb1_rd  in  ROB_SZ_LOG+1 each  result-bus tags.
REQ-012 cdb0_res, cdb1_res  in  32 each  result-bus values.
REQ-013 full  out  1  registered back-pressure to dispatcher.
REQ-014 run_flg  out  1  issue valid to ALU, registered.
REQ-015 rd_fr  out  ROB_SZ_LOG+1  issued destination tag, registered.
REQ-016 Vj, Vk, imm, pc  out  32 each  issued operands, registered.
REQ-017 opcode, optype  out  4 each  issued operation, registered.

Function
REQ-018 Per entry SHALL hold: busy, opcode, optype, Vj, Qj, Vk, Qk, imm, pc, rd; occupancy counter count (0..RS_SIZE).
REQ-019 Dispatch: in_flg=1 with rdy=1, clr=0 SHALL write the lowest-index non-busy entry at that edge.
REQ-020 Dispatch with count==RS_SIZE is illegal; block SHALL drop it and leave state unchanged.
REQ-021 full SHALL be registered as (next count >= RS_SIZE-1), giving dispatcher one cycle of slack.
REQ-022 Wakeup: for each busy entry and each cdbN with cdbN_flg=1, Qj==cdbN_rd and Qj!=0 SHALL set Vj<=cdbN_res, Qj<=0; same for Qk/Vk.
REQ-023 Dispatch-cycle capture: incoming in_Qj/in_Qk matching a valid CDB tag that cycle SHALL be stored resolved (value from CDB, Q=0); cdb0 wins if both match.
REQ-024 Ready = busy && Qj==0 && Qk==0, evaluated on entry state at start of cycle; entries woken or dispatched in cycle N SHALL be issue-eligible no earlier than cycle N+1.
REQ-025 Issue: at most one entry per edge; selected entry's fields SHALL load the output registers, run_flg<=1, entry busy<=0.
REQ-026 No ready entry SHALL give run_flg<=0; other outputs hold last values.
REQ-027 run_flg SHALL be high for exactly one cycle per issued entry.
REQ-028 Simultaneous dispatch and issue SHALL both occur; count net unchanged; freed slot not reused the same edge.
REQ-029 clr=1 (with rdy=1) SHALL clear all busy bits, count<=0, full<=0, run_flg<=0, overriding dispatch, wakeup and issue.
REQ-030 rdy=0 SHALL freeze all entries and count, and register run_flg<=0.
REQ-031 Minimum latency: ready instruction dispatched at edge N SHALL present run_flg=1 after edge N+1.

Reset
REQ-032 rst low at rising edge SHALL clear all busy bits, count=0, full=0, run_flg=0, rd_fr/Vj/Vk/imm/pc/opcode/optype=0; rst dominates clr and rdy.
REQ-033 Reset mid-operation SHALL discard all entries with no issue that edge.

Configuration
REQ-034 Macro ALU_RS_AGE_EN defined: each busy entry SHALL carry a 4-bit age counter (0 on dispatch, +1 per cycle, saturating at 15); select SHALL pick the ready entry with largest age, ties to lowest index.
REQ-035 Macro ALU_RS_AGE_EN undefined: no age state; select SHALL pick the lowest-index ready entry.

Verification
REQ-036 Reset then dispatch ADDI, Vj=5, imm=3, Qj=Qk=0, rd=2 -> run_flg=1 after next edge, rd_fr=2, Vj=5, imm=3, one cycle only.
REQ-037 Dispatch ADD, Qj=4, rd=6; two cycles later cdb1_flg=1, rd=4, res=0x10 -> issue next cycle with Vj=0x10, rd_fr=6.
REQ-038 Dispatch with in_Qk=3 same cycle as cdb0 rd=3, res=7 -> entry issues after next edge with Vk=7.
REQ-039 Fill 7 waiting entries -> full=1; one issues -> full=0 following cycle; no dispatch dropped.
REQ-040 Two ready entries, slot 1 older than slot 0 -> AGE_EN: slot 1 issues first; without: slot 0 first.
REQ-041 clr=1 with 3 busy entries and dispatch in_flg=1 -> next cycle count=0, run_flg=0, no later issue of any of them.
